// File: rtl/util_tx_time_gate.sv
// Launch-time gate for TX DMA bursts: holds each burst until `timestamp`
// reaches the header's launch time, drops late bursts, counts late/underflow.
module util_tx_time_gate #(
    parameter int DATA_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [63:0]           timestamp,
    input  logic                  enable,
    input  logic [31:0]           burst_beats,
    input  logic                  clear_counts,
    input  logic                  s_axis_valid,
    output logic                  s_axis_ready,
    input  logic [DATA_WIDTH-1:0] s_axis_data,
    input  logic                  s_axis_xfer_req,
    output logic                  m_axis_valid,
    input  logic                  m_axis_ready,
    output logic [DATA_WIDTH-1:0] m_axis_data,
    output logic                  m_axis_xfer_req,
    output logic [31:0]           late_count,
    output logic [31:0]           underflow_count,
    output logic [2:0]            state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR   = 3'd1,
        CHECK = 3'd2,
        WAIT  = 3'd3,
        PASS  = 3'd4,
        DROP  = 3'd5
    } state_t;

    state_t      st;
    logic [63:0] hdr_ts;
    logic [31:0] beat_cnt;
    logic [31:0] beats_l;

    logic s_hs, last_beat, pass_thru, is_late, underflow, late_inc;

    assign state     = st;
    assign s_hs      = s_axis_valid && s_axis_ready;
    assign pass_thru = (beats_l == 32'd0);
    assign last_beat = (beat_cnt == beats_l - 32'd1);
    assign is_late   = (hdr_ts < timestamp);
    assign underflow = (st == PASS) && m_axis_ready && !s_axis_valid;
    assign late_inc  = (st == CHECK) && s_axis_xfer_req && is_late;

    // Stream path is purely combinational in PASS; gating on resetn keeps any
    // beat from being accepted during a reset cycle.
    always_comb begin
        s_axis_ready = 1'b0;
        m_axis_valid = 1'b0;
        m_axis_data  = '0;
        if (resetn) begin
            case (st)
                HDR, DROP: s_axis_ready = 1'b1;
                PASS: begin
                    s_axis_ready = m_axis_ready;
                    m_axis_valid = s_axis_valid;
                    m_axis_data  = s_axis_data;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            st              <= IDLE;
            hdr_ts          <= '0;
            beat_cnt        <= '0;
            beats_l         <= '0;
            late_count      <= '0;
            underflow_count <= '0;
            m_axis_xfer_req <= 1'b0;
        end else begin
            m_axis_xfer_req <= s_axis_xfer_req && (st != IDLE);

            if (clear_counts)
                late_count <= '0;
            else if (late_inc && late_count != 32'hFFFF_FFFF)
                late_count <= late_count + 32'd1;

            if (clear_counts)
                underflow_count <= '0;
            else if (underflow && underflow_count != 32'hFFFF_FFFF)
                underflow_count <= underflow_count + 32'd1;

            // Losing xfer_req abandons whatever burst is in flight.
            if (!s_axis_xfer_req) begin
                st       <= IDLE;
                beat_cnt <= '0;
            end else begin
                case (st)
                    IDLE: if (enable) begin
                        beats_l <= burst_beats;
                        st      <= (burst_beats == 32'd0) ? PASS : HDR;
                    end
                    HDR: if (s_hs) begin
                        hdr_ts <= s_axis_data[63:0];
                        st     <= CHECK;
                    end
                    CHECK: st <= is_late ? DROP : WAIT;
                    WAIT:  if (timestamp >= hdr_ts) st <= PASS;
                    PASS, DROP: if (s_hs && !pass_thru) begin
                        if (last_beat) begin
                            beat_cnt <= '0;
                            st       <= HDR;
                        end else begin
                            beat_cnt <= beat_cnt + 32'd1;
                        end
                    end
                    default: st <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_util_tx_time_gate.sv
// Bench for util_tx_time_gate: burst table plus hand sequences, with a
// scoreboard queue matching forwarded beats against what was sent.
module tb_util_tx_time_gate;
    localparam int DW = 128;
    localparam logic [2:0] S_IDLE = 3'd0, S_HDR = 3'd1, S_CHECK = 3'd2,
                           S_WAIT = 3'd3, S_PASS = 3'd4, S_DROP = 3'd5;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [63:0]   timestamp = 64'd0;
    logic          enable = 1'b0;
    logic [31:0]   burst_beats = 32'd0;
    logic          clear_counts = 1'b0;
    logic          s_axis_valid = 1'b0;
    logic          s_axis_ready;
    logic [DW-1:0] s_axis_data = '0;
    logic          s_axis_xfer_req = 1'b0;
    logic          m_axis_valid;
    logic          m_axis_ready = 1'b0;
    logic [DW-1:0] m_axis_data;
    logic          m_axis_xfer_req;
    logic [31:0]   late_count;
    logic [31:0]   underflow_count;
    logic [2:0]    state;

    util_tx_time_gate #(.DATA_WIDTH(DW)) dut (
        .clk(clk), .resetn(resetn), .timestamp(timestamp), .enable(enable),
        .burst_beats(burst_beats), .clear_counts(clear_counts),
        .s_axis_valid(s_axis_valid), .s_axis_ready(s_axis_ready),
        .s_axis_data(s_axis_data), .s_axis_xfer_req(s_axis_xfer_req),
        .m_axis_valid(m_axis_valid), .m_axis_ready(m_axis_ready),
        .m_axis_data(m_axis_data), .m_axis_xfer_req(m_axis_xfer_req),
        .late_count(late_count), .underflow_count(underflow_count), .state(state)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] sb[$];
    int            fwd_cnt = 0;
    bit            seen_vld = 0;
    logic [63:0]   first_vld_ts = 64'd0;

    typedef struct {
        logic [31:0] beats;
        longint      delta;     // launch time relative to the CHECK-cycle timestamp
        bit          late;
        logic [31:0] exp_late;
    } vec_t;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Downstream monitor: every handshake must match the head of the scoreboard.
    always @(negedge clk) begin
        if (resetn && m_axis_valid && m_axis_ready) begin
            if (!seen_vld) begin
                seen_vld     = 1;
                first_vld_ts = timestamp;
            end
            fwd_cnt++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got data %0h, expected no beat", m_axis_data);
            end else begin
                chk("beat_data", m_axis_data, sb.pop_front());
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        timestamp = timestamp + 64'd1;
    endtask

    function automatic logic [DW-1:0] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic send_beat(input logic [DW-1:0] d, input bit fwd, input bit rnd_rdy);
        bit done = 0;
        int n = 0;
        s_axis_valid = 1'b1;
        s_axis_data  = d;
        while (!done) begin
            if (rnd_rdy) m_axis_ready = 1'($urandom_range(0, 1));
            #1;
            if (s_axis_ready) begin
                if (fwd) sb.push_back(d);
                done = 1;
            end
            cyc();
            n++;
            if (!done && n > 300) begin
                checks++;
                errors++;
                $display("FAIL beat_timeout: got no s_axis_ready in %0d cycles, expected accept", n);
                done = 1;
            end
        end
        s_axis_valid = 1'b0;
    endtask

    task automatic send_hdr(input bit abs_ts, input logic [63:0] abs_val, input longint delta);
        bit done = 0;
        int n = 0;
        s_axis_valid = 1'b1;
        while (!done) begin
            #1;
            if (s_axis_ready) begin
                s_axis_data = {64'hA5A5_0000_DEAD_BEEF,
                               abs_ts ? abs_val : timestamp + 64'd1 + 64'(delta)};
                done = 1;
            end
            cyc();
            n++;
            if (!done && n > 300) begin
                checks++;
                errors++;
                $display("FAIL hdr_timeout: got no header accept, expected accept");
                done = 1;
            end
        end
        s_axis_valid = 1'b0;
    endtask

    task automatic start_xfer(input logic [31:0] beats);
        m_axis_ready    = 1'b0;
        s_axis_xfer_req = 1'b0;
        cyc();
        chk("xfer_drop_idle", state, S_IDLE);
        burst_beats     = beats;
        s_axis_xfer_req = 1'b1;
        cyc();
        chk("xfer_start_state", state, (beats == 0) ? S_PASS : S_HDR);
    endtask

    vec_t vt[5];
    int   f0;

    initial begin
        vt[0] = '{beats: 32'd4, delta: -300, late: 1'b1, exp_late: 32'd1};
        vt[1] = '{beats: 32'd4, delta: 3,    late: 1'b0, exp_late: 32'd1};
        vt[2] = '{beats: 32'd2, delta: 0,    late: 1'b0, exp_late: 32'd1};
        vt[3] = '{beats: 32'd1, delta: -1,   late: 1'b1, exp_late: 32'd2};
        vt[4] = '{beats: 32'd3, delta: 10,   late: 1'b0, exp_late: 32'd2};

        // Reset state
        cyc(); cyc();
        chk("rst_state", state, S_IDLE);
        chk("rst_s_ready", s_axis_ready, 0);
        chk("rst_m_valid", m_axis_valid, 0);
        chk("rst_m_xfer", m_axis_xfer_req, 0);
        chk("rst_m_data", m_axis_data, 0);
        chk("rst_late", late_count, 0);
        chk("rst_under", underflow_count, 0);
        resetn = 1'b1;
        enable = 1'b1;

        // Future burst: header 1000 arriving at timestamp 900
        start_xfer(32'd4);
        m_axis_ready = 1'b1;
        timestamp = 64'd900;
        seen_vld = 0;
        f0 = fwd_cnt;
        send_hdr(1'b1, 64'd1000, 0);
        for (int i = 0; i < 4; i++) send_beat(rnd_data(), 1'b1, 1'b0);
        chk("future_first_ts", first_vld_ts, 64'd1001);
        chk("future_fwd", fwd_cnt - f0, 4);
        chk("future_state", state, S_HDR);
        chk("future_late", late_count, 0);
        chk("future_m_xfer", m_axis_xfer_req, 1);

        // Burst table
        for (int v = 0; v < 5; v++) begin
            start_xfer(vt[v].beats);
            m_axis_ready = 1'b1;
            f0 = fwd_cnt;
            send_hdr(1'b0, 64'd0, vt[v].delta);
            cyc();
            chk("vec_decision", state, vt[v].late ? S_DROP : S_WAIT);
            chk("vec_late_now", late_count, vt[v].exp_late);
            for (int i = 0; i < int'(vt[v].beats); i++)
                send_beat(rnd_data(), !vt[v].late, 1'b0);
            chk("vec_end_state", state, S_HDR);
            chk("vec_fwd", fwd_cnt - f0, vt[v].late ? 0 : int'(vt[v].beats));
            chk("vec_sb_empty", sb.size(), 0);
            chk("vec_under", underflow_count, 0);
        end

        // Underflow: 3 idle cycles mid-burst with downstream ready
        start_xfer(32'd5);
        m_axis_ready = 1'b1;
        f0 = fwd_cnt;
        send_hdr(1'b0, 64'd0, 2);
        for (int i = 0; i < 2; i++) send_beat(rnd_data(), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cyc();
        for (int i = 0; i < 3; i++) send_beat(rnd_data(), 1'b1, 1'b0);
        chk("under_count", underflow_count, 3);
        chk("under_fwd", fwd_cnt - f0, 5);
        chk("under_state", state, S_HDR);

        // Pass-through with random downstream ready
        start_xfer(32'd0);
        f0 = fwd_cnt;
        for (int i = 0; i < 10; i++) send_beat(rnd_data(), 1'b1, 1'b1);
        m_axis_ready = 1'b0;
        chk("pt_fwd", fwd_cnt - f0, 10);
        chk("pt_state", state, S_PASS);
        chk("pt_late", late_count, 2);
        chk("pt_sb_empty", sb.size(), 0);

        // Abort after beat 2 of 4, then a fresh transfer must start with a header
        start_xfer(32'd4);
        m_axis_ready = 1'b1;
        f0 = fwd_cnt;
        send_hdr(1'b0, 64'd0, 2);
        for (int i = 0; i < 2; i++) send_beat(rnd_data(), 1'b1, 1'b0);
        m_axis_ready    = 1'b0;
        s_axis_xfer_req = 1'b0;
        cyc();
        chk("abort_state", state, S_IDLE);
        chk("abort_m_xfer", m_axis_xfer_req, 0);
        s_axis_xfer_req = 1'b1;
        cyc();
        chk("abort_restart", state, S_HDR);
        m_axis_ready = 1'b1;
        send_hdr(1'b0, 64'd0, 2);
        for (int i = 0; i < 4; i++) send_beat(rnd_data(), 1'b1, 1'b0);
        chk("abort_fwd", fwd_cnt - f0, 6);
        chk("abort_end_state", state, S_HDR);

        // Reset while waiting
        send_hdr(1'b0, 64'd0, 30);
        cyc();
        chk("wait_state", state, S_WAIT);
        s_axis_valid = 1'b1;
        s_axis_data  = rnd_data();
        resetn = 1'b0;
        #1;
        chk("rst_cycle_ready", s_axis_ready, 0);
        cyc();
        chk("rst2_state", state, S_IDLE);
        chk("rst2_s_ready", s_axis_ready, 0);
        chk("rst2_m_valid", m_axis_valid, 0);
        chk("rst2_m_xfer", m_axis_xfer_req, 0);
        chk("rst2_m_data", m_axis_data, 0);
        chk("rst2_late", late_count, 0);
        chk("rst2_under", underflow_count, 0);
        s_axis_valid = 1'b0;
        resetn = 1'b1;

        // Late counter saturation, then clear colliding with an increment
        start_xfer(32'd1);
        m_axis_ready = 1'b1;
        force dut.late_count = 32'hFFFF_FFFE;
        #1;
        release dut.late_count;
        chk("sat_preload", late_count, 32'hFFFF_FFFE);
        for (int k = 0; k < 3; k++) begin
            send_hdr(1'b0, 64'd0, -5);
            cyc();
            chk("sat_late", late_count, 32'hFFFF_FFFF);
            send_beat(rnd_data(), 1'b0, 1'b0);
        end
        chk("sat_state", state, S_HDR);
        send_hdr(1'b0, 64'd0, -5);
        chk("clr_in_check", state, S_CHECK);
        clear_counts = 1'b1;
        cyc();
        clear_counts = 1'b0;
        chk("clr_late", late_count, 0);
        chk("clr_state", state, S_DROP);
        send_beat(rnd_data(), 1'b0, 1'b0);
        chk("clr_end_state", state, S_HDR);
        chk("final_sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
